// File: rtl/apb_uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : apb_uart_pkg
//  Description : Shared types and constants for the UART TX arbitration path.
//  Revision    : 1.0 - initial release
// ============================================================================
package apb_uart_pkg;

  // Upper bound on the number of byte-stream sources feeding the TX FIFO.
  localparam int UART_ARB_MAX_REQ = 8;

  // Arbiter FSM: IDLE picks a winner, LOCKED streams the winner's bytes.
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

endpackage : apb_uart_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin picker. Returns a one-hot grant for
//                the first eligible index strictly after i_ptr, wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] i_eligible,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant
);

  logic             w_found;
  logic [PTR_W-1:0] w_idx;

  // Scan from ptr+1 around to ptr itself so the last winner has lowest priority.
  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_idx = PTR_W'((int'(i_ptr) + i) % NUM_REQ);
      if (!w_found && i_eligible[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/uart_tx_arb.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arb
//  Description : Round-robin arbiter that locks one byte-stream requester onto
//                the TX FIFO write port until end-of-message, burst limit, or
//                the requester being disabled.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arb
  import apb_uart_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int MAX_BURST = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_REQ-1:0]      req_en_i,
  input  logic [NUM_REQ-1:0][7:0] req_data_i,
  input  logic [NUM_REQ-1:0]      req_last_i,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  output logic [7:0]              tx_data_o,
  output logic                    tx_valid_o,
  input  logic                    tx_ready_i,
  output logic [NUM_REQ-1:0]      grant_o,
  output logic                    busy_o
);

  localparam int         c_PTR_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0] c_BURST_LIMIT = 8'(MAX_BURST);

  arb_state_e           r_state,     w_state_next;
  logic [NUM_REQ-1:0]   r_grant,     w_grant_next;
  logic [c_PTR_W-1:0]   r_grant_idx, w_grant_idx_next;
  logic [c_PTR_W-1:0]   r_last_ptr,  w_last_ptr_next;
  logic [7:0]           r_beat_cnt,  w_beat_cnt_next;

  logic [NUM_REQ-1:0]   w_eligible;
  logic [NUM_REQ-1:0]   w_arb_grant;
  logic [c_PTR_W-1:0]   w_arb_idx;
  logic                 w_grant_en;
  logic                 w_beat;

  assign w_eligible = req_valid_i & req_en_i;
  assign w_grant_en = |(req_en_i & r_grant);
  assign grant_o    = r_grant;
  assign busy_o     = (r_state == LOCKED);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (c_PTR_W)
  ) u_rr_arbiter (
    .i_eligible (w_eligible),
    .i_ptr      (r_last_ptr),
    .o_grant    (w_arb_grant)
  );

  // Encode the arbiter's one-hot winner into an index for the mux.
  always_comb begin
    w_arb_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_arb_grant[i]) begin
        w_arb_idx = c_PTR_W'(i);
      end
    end
  end

  // Next-state logic plus the granted requester's pass-through to the FIFO.
  always_comb begin
    w_state_next     = r_state;
    w_grant_next     = r_grant;
    w_grant_idx_next = r_grant_idx;
    w_last_ptr_next  = r_last_ptr;
    w_beat_cnt_next  = r_beat_cnt;
    tx_valid_o       = 1'b0;
    tx_data_o        = '0;
    req_ready_o      = '0;
    w_beat           = 1'b0;

    case (r_state)
      IDLE: begin
        if (|w_eligible) begin
          w_state_next     = LOCKED;
          w_grant_next     = w_arb_grant;
          w_grant_idx_next = w_arb_idx;
          w_beat_cnt_next  = 8'd0;
        end
      end

      LOCKED: begin
        if (!w_grant_en) begin
          // Disabled owner loses the grant without moving a byte this cycle.
          w_state_next    = IDLE;
          w_grant_next    = '0;
          w_last_ptr_next = r_grant_idx;
        end else begin
          // Reset gating keeps an in-flight byte from escaping in the reset cycle.
          if (!rst_i) begin
            tx_valid_o               = req_valid_i[r_grant_idx];
            tx_data_o                = req_data_i[r_grant_idx];
            req_ready_o[r_grant_idx] = tx_ready_i;
          end
          w_beat = tx_valid_o & tx_ready_i;
          if (w_beat) begin
            w_beat_cnt_next = r_beat_cnt + 8'd1;
            if (req_last_i[r_grant_idx] || ((r_beat_cnt + 8'd1) == c_BURST_LIMIT)) begin
              w_state_next    = IDLE;
              w_grant_next    = '0;
              w_last_ptr_next = r_grant_idx;
            end
          end
        end
      end

      default: begin
        w_state_next = IDLE;
        w_grant_next = '0;
      end
    endcase
  end

  // State register; pointer resets to the top index so requester 0 wins first.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_grant_idx <= '0;
      r_last_ptr  <= c_PTR_W'(NUM_REQ - 1);
      r_beat_cnt  <= 8'd0;
    end else begin
      r_state     <= w_state_next;
      r_grant     <= w_grant_next;
      r_grant_idx <= w_grant_idx_next;
      r_last_ptr  <= w_last_ptr_next;
      r_beat_cnt  <= w_beat_cnt_next;
    end
  end

endmodule : uart_tx_arb
`default_nettype wire

// File: tb/tb_uart_tx_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_arb
//  Description : Self-checking bench for uart_tx_arb (NUM_REQ=4, MAX_BURST=16).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arb;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      en;
  logic [3:0][7:0] data;
  logic [3:0]      last;
  logic [3:0]      valid;
  logic [3:0]      ready;
  logic [7:0]      tx_data;
  logic            tx_valid;
  logic            tx_ready;
  logic [3:0]      grant;
  logic            busy;

  int checks = 0;
  int errors = 0;
  int beats  = 0;
  int b0;

  typedef struct packed {
    logic        rst;
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [31:0] data;
    logic [3:0]  exp_grant;
    logic        exp_busy;
    logic        exp_txv;
    logic [7:0]  exp_txd;
    logic [3:0]  exp_rdy;
  } vec_t;

  vec_t vecs [20];

  uart_tx_arb #(
    .NUM_REQ   (4),
    .MAX_BURST (16)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_en_i    (en),
    .req_data_i  (data),
    .req_last_i  (last),
    .req_valid_i (valid),
    .req_ready_o (ready),
    .tx_data_o   (tx_data),
    .tx_valid_o  (tx_valid),
    .tx_ready_i  (tx_ready),
    .grant_o     (grant),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  // Count accepted bytes at the FIFO write port.
  always @(posedge clk) begin
    if (tx_valid && tx_ready) beats <= beats + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 4'hF; valid = '0; last = '0; data = '0; tx_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    // rst, valid, last, data, grant, busy, txv, txd, rdy
    vecs[0]  = '{1'b0, 4'h0, 4'h0, 32'h0000_0000, 4'h0, 1'b0, 1'b0, 8'h00, 4'h0};
    vecs[1]  = '{1'b0, 4'h3, 4'h0, 32'h0000_A041, 4'h0, 1'b0, 1'b0, 8'h00, 4'h0};
    vecs[2]  = '{1'b0, 4'h3, 4'h0, 32'h0000_A041, 4'h1, 1'b1, 1'b1, 8'h41, 4'h1};
    vecs[3]  = '{1'b0, 4'h3, 4'h0, 32'h0000_A042, 4'h1, 1'b1, 1'b1, 8'h42, 4'h1};
    vecs[4]  = '{1'b0, 4'h3, 4'h1, 32'h0000_A043, 4'h1, 1'b1, 1'b1, 8'h43, 4'h1};
    vecs[5]  = '{1'b0, 4'h2, 4'h2, 32'h0000_A000, 4'h0, 1'b0, 1'b0, 8'h00, 4'h0};
    vecs[6]  = '{1'b0, 4'h2, 4'h2, 32'h0000_A000, 4'h2, 1'b1, 1'b1, 8'hA0, 4'h2};
    vecs[7]  = '{1'b0, 4'h0, 4'h0, 32'h0000_0000, 4'h0, 1'b0, 1'b0, 8'h00, 4'h0};
    vecs[8]  = '{1'b1, 4'h0, 4'h0, 32'h0000_0000, 4'h0, 1'b0, 1'b0, 8'h00, 4'h0};
    vecs[9]  = '{1'b0, 4'hF, 4'hF, 32'h1312_1110, 4'h0, 1'b0, 1'b0, 8'h00, 4'h0};
    vecs[10] = '{1'b0, 4'hF, 4'hF, 32'h1312_1110, 4'h1, 1'b1, 1'b1, 8'h10, 4'h1};
    vecs[11] = '{1'b0, 4'hF, 4'hF, 32'h1312_1110, 4'h0, 1'b0, 1'b0, 8'h00, 4'h0};
    vecs[12] = '{1'b0, 4'hF, 4'hF, 32'h1312_1110, 4'h2, 1'b1, 1'b1, 8'h11, 4'h2};
    vecs[13] = '{1'b0, 4'hF, 4'hF, 32'h1312_1110, 4'h0, 1'b0, 1'b0, 8'h00, 4'h0};
    vecs[14] = '{1'b0, 4'hF, 4'hF, 32'h1312_1110, 4'h4, 1'b1, 1'b1, 8'h12, 4'h4};
    vecs[15] = '{1'b0, 4'hF, 4'hF, 32'h1312_1110, 4'h0, 1'b0, 1'b0, 8'h00, 4'h0};
    vecs[16] = '{1'b0, 4'hF, 4'hF, 32'h1312_1110, 4'h8, 1'b1, 1'b1, 8'h13, 4'h8};
    vecs[17] = '{1'b0, 4'hF, 4'hF, 32'h1312_1110, 4'h0, 1'b0, 1'b0, 8'h00, 4'h0};
    vecs[18] = '{1'b0, 4'hF, 4'hF, 32'h1312_1110, 4'h1, 1'b1, 1'b1, 8'h10, 4'h1};
    vecs[19] = '{1'b0, 4'h0, 4'h0, 32'h0000_0000, 4'h0, 1'b0, 1'b0, 8'h00, 4'h0};

    // Per-cycle vectors: two-requester message handoff, then 4-way rotation.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      rst = vecs[i].rst; valid = vecs[i].valid; last = vecs[i].last; data = vecs[i].data;
      @(negedge clk);
      chk($sformatf("vec%0d_grant", i), 32'(grant),    32'(vecs[i].exp_grant));
      chk($sformatf("vec%0d_busy", i),  32'(busy),     32'(vecs[i].exp_busy));
      chk($sformatf("vec%0d_txv", i),   32'(tx_valid), 32'(vecs[i].exp_txv));
      chk($sformatf("vec%0d_txd", i),   32'(tx_data),  32'(vecs[i].exp_txd));
      chk($sformatf("vec%0d_rdy", i),   32'(ready),    32'(vecs[i].exp_rdy));
      step();
    end

    // Burst limit: req 1 streams without last, forced off after 16 beats.
    do_reset();
    valid = 4'b0010; data[1] = 8'd1;
    @(negedge clk); chk("burst_idle_busy", 32'(busy), 32'd0);
    step();
    for (int k = 1; k <= 16; k++) begin
      data[1] = 8'(k);
      if (k == 2) begin valid[0] = 1'b1; data[0] = 8'h55; last[0] = 1'b1; end
      @(negedge clk);
      chk($sformatf("burst_grant_%0d", k), 32'(grant),   32'h2);
      chk($sformatf("burst_data_%0d", k),  32'(tx_data), 32'(k));
      step();
    end
    @(negedge clk);
    chk("burst_release_busy",  32'(busy),  32'd0);
    chk("burst_release_grant", 32'(grant), 32'h0);
    data[1] = 8'd17;
    step();
    @(negedge clk);
    chk("burst_req0_grant", 32'(grant),   32'h1);
    chk("burst_req0_data",  32'(tx_data), 32'h55);
    step();
    valid[0] = 1'b0; last[0] = 1'b0;
    @(negedge clk); chk("burst_gap_busy", 32'(busy), 32'd0);
    step();
    last[1] = 1'b1;
    @(negedge clk);
    chk("burst_resume_grant", 32'(grant),   32'h2);
    chk("burst_resume_data",  32'(tx_data), 32'd17);
    step();
    valid = '0; last = '0;

    // FIFO back-pressure: byte held for 5 cycles, nothing lost or repeated.
    do_reset();
    valid = 4'b0001; data[0] = 8'h61;
    step();
    @(negedge clk);
    chk("stall_first_data", 32'(tx_data), 32'h61);
    b0 = beats;
    step();
    data[0] = 8'h62; tx_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("stall_data_%0d", k),  32'(tx_data),  32'h62);
      chk($sformatf("stall_grant_%0d", k), 32'(grant),    32'h1);
      chk($sformatf("stall_txv_%0d", k),   32'(tx_valid), 32'd1);
      chk($sformatf("stall_rdy_%0d", k),   32'(ready),    32'h0);
      step();
    end
    tx_ready = 1'b1;
    @(negedge clk);
    chk("stall_resume_data", 32'(tx_data), 32'h62);
    chk("stall_resume_rdy",  32'(ready),   32'h1);
    step();
    data[0] = 8'h63; last[0] = 1'b1;
    @(negedge clk); chk("stall_last_data", 32'(tx_data), 32'h63);
    step();
    chk("stall_beat_total", 32'(beats - b0), 32'd3);
    @(negedge clk); chk("stall_done_busy", 32'(busy), 32'd0);
    valid = '0; last = '0;

    // Owner disabled mid-message: no beat that cycle, release, next winner.
    do_reset();
    valid = 4'b0011; data[0] = 8'h70; data[1] = 8'h80;
    step();
    @(negedge clk); chk("endrop_first_data", 32'(tx_data), 32'h70);
    step();
    en = 4'b1110; b0 = beats;
    @(negedge clk);
    chk("endrop_txv",  32'(tx_valid), 32'd0);
    chk("endrop_rdy",  32'(ready),    32'h0);
    chk("endrop_busy", 32'(busy),     32'd1);
    step();
    chk("endrop_no_beat", 32'(beats - b0), 32'd0);
    @(negedge clk);
    chk("endrop_idle_busy",  32'(busy),  32'd0);
    chk("endrop_idle_grant", 32'(grant), 32'h0);
    last[1] = 1'b1;
    step();
    @(negedge clk);
    chk("endrop_next_grant", 32'(grant),   32'h2);
    chk("endrop_next_data",  32'(tx_data), 32'h80);
    chk("endrop_next_rdy",   32'(ready),   32'h2);
    step();
    valid = '0; last = '0; en = 4'hF;

    // Reset on the 2nd byte of a message: abandoned, req 0 regranted first.
    do_reset();
    valid = 4'b0001; data[0] = 8'h91;
    step();
    @(negedge clk); chk("rstmid_first_data", 32'(tx_data), 32'h91);
    step();
    data[0] = 8'h92; rst = 1'b1; b0 = beats;
    @(negedge clk);
    chk("rstmid_txv", 32'(tx_valid), 32'd0);
    chk("rstmid_rdy", 32'(ready),    32'h0);
    step();
    chk("rstmid_no_beat", 32'(beats - b0), 32'd0);
    rst = 1'b0; valid = 4'b0011;
    @(negedge clk);
    chk("rstmid_busy",  32'(busy),     32'd0);
    chk("rstmid_grant", 32'(grant),    32'h0);
    chk("rstmid_txv0",  32'(tx_valid), 32'd0);
    chk("rstmid_txd0",  32'(tx_data),  32'h0);
    last[0] = 1'b1;
    step();
    @(negedge clk);
    chk("rstmid_regrant", 32'(grant),   32'h1);
    chk("rstmid_data",    32'(tx_data), 32'h92);
    step();
    valid = '0; last = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case the sequence above ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule : tb_uart_tx_arb
`default_nettype wire

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter NUM_REQ, default 2, number of byte-stream requesters (2..8).
REQ-002 Parameter MAX_BURST, default 16, maximum beats per grant before forced release (1..255).
REQ-003 clk_i  input  1  single clock; all logic rising-edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 req_en_i  input  NUM_REQ  per-requester enable mask, from config register.
REQ-006 req_data_i  input  NUM_REQ x 8  per-requester byte.
REQ-007 req_last_i  input  NUM_REQ  per-requester end-of-message flag.
REQ-008 req_valid_i  input  NUM_REQ  per-requester valid.
REQ-009 req_ready_o  output  NUM_REQ  per-requester ready.
REQ-010 tx_data_o  output  8  byte to TX FIFO write side.
REQ-011 tx_valid_o  output  1  valid to TX FIFO.
REQ-012 tx_ready_i  input  1  TX FIFO ready (not full).
REQ-013 grant_o  output  NUM_REQ  one-hot current grant, all-zero when idle.
REQ-014 busy_o  output  1  high in state LOCKED.

Function
REQ-015 State machine SHALL have two states: IDLE, LOCKED.
REQ-016 IDLE: eligible = req_valid_i AND req_en_i; if nonzero, SHALL register a grant to the first eligible index after last-granted index (round-robin, wrapping NUM_REQ-1 -> 0), go LOCKED next cycle; no beat transfers in IDLE.
REQ-017 Grant latency: valid asserted in cycle N on idle arbiter -> grant_o set and transfer possible in cycle N+1.
REQ-018 LOCKED: tx_data_o/tx_valid_o SHALL be combinational pass-through of granted requester; req_ready_o[g] = tx_ready_i; all other req_ready_o bits 0.
REQ-019 Beat = tx_valid_o AND tx_ready_i; beat counter (8-bit) increments per beat, cleared on entry to LOCKED.
REQ-020 LOCKED -> IDLE after a beat with req_last_i[g]=1, or after the beat making count equal MAX_BURST, whichever first.
REQ-021 On release, last-granted pointer SHALL update to g, so g has lowest priority in the next arbitration.
REQ-022 If req_en_i[g] deasserts while LOCKED, SHALL release to IDLE next cycle without transferring in that cycle (req_ready_o[g]=0 that cycle).
REQ-023 Requester dropping valid while LOCKED SHALL NOT release grant (bubbles allowed).
REQ-024 tx_ready_i low SHALL stall without changing grant or counter.
REQ-025 Simultaneous last and MAX_BURST on same beat: single release, pointer updated once.
REQ-026 tx_valid_o SHALL be 0 and tx_data_o 0 in IDLE.

Reset
REQ-027 rst_i SHALL, on the next edge, force IDLE, grant_o=0, busy_o=0, beat counter=0, last-granted pointer=NUM_REQ-1 (so requester 0 wins first).
REQ-028 Reset mid-message SHALL abandon the message; no beat transferred in the reset cycle; req_ready_o=0 while rst_i high.

Structure
REQ-029 Typedef arb_state_e (IDLE, LOCKED) and constant UART_ARB_MAX_REQ=8 SHALL live in apb_uart_pkg.
REQ-030 Round-robin selection SHALL be a sub-module rr_arbiter (inputs eligible mask and pointer, output one-hot grant, combinational).
REQ-031 Block instantiated between register interface / auxiliary sources and TX FIFO write side.

Verification
REQ-032 Reset, then req 0 and 1 valid same cycle -> req 0 granted cycle+1; req 0 sends 3 bytes 0x41,0x42,0x43 (last on 0x43) -> req 1 granted next, no interleaving.
REQ-033 Req 1 streams 20 bytes no last, MAX_BURST=16 -> release after 16th beat; req 0 pending wins; req 1 resumes later with byte 17.
REQ-034 tx_ready_i low 5 cycles mid-message -> tx_data_o held, counter unchanged, grant unchanged, no lost/duplicated byte.
REQ-035 req_en_i[0] cleared while req 0 LOCKED -> IDLE next cycle, no beat that cycle, req 1 granted cycle after.
REQ-036 rst_i asserted on 2nd of 4 bytes -> IDLE, outputs zero, after release req 0 regranted first.
REQ-037 NUM_REQ=4, all valid continuously, 1-byte messages -> grant order 0,1,2,3,0 with one idle cycle between grants.
